// File: rtl/loader_pkg.sv
// Shared constants for the boot-time program loader: FSM encoding, stream framing
// and checksum seed. LOADER_CHECKSUM_EN enables the trailing checksum byte.
package loader_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CSUM   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    localparam int         LEN_BYTES      = 2;
    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] CSUM_INIT      = 8'h00;

endpackage

// File: rtl/program_loader_word_packer.sv
// Packs a byte stream MSB-first into 32-bit words; o_word_valid pulses for one
// cycle after the edge that takes the fourth byte, and o_word holds until the next word.
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstd,
    input  logic        i_clr,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_last_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_idx;
    logic [23:0] r_shift;
    logic [31:0] r_word;
    logic        r_word_valid;

    assign o_last_byte  = (r_idx == 2'(BYTES_PER_WORD - 1));
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            r_idx        <= 2'd0;
            r_shift      <= 24'd0;
            r_word       <= 32'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clr) begin
                r_idx <= 2'd0;
            end else if (i_byte_valid) begin
                r_shift <= {r_shift[15:0], i_byte};
                r_idx   <= r_idx + 2'd1;
                if (o_last_byte) begin
                    r_word       <= {r_shift, i_byte};
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed byte image, writes 32-bit words to
// instruction memory from address 0, then releases the core. Optional: LOADER_CHECKSUM_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rstd,
    output logic              done,
    output logic              error
);

`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_TAIL    = ST_CSUM;
    localparam logic       TAIL_READY = 1'b1;
`else
    localparam logic [2:0] ST_TAIL    = ST_DONE;
    localparam logic       TAIL_READY = 1'b0;
`endif

    logic [2:0]        r_state;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [ADDR_W:0]   r_widx;
    logic              r_rx_ready;
    logic              r_done;
    logic              r_error;
    logic              r_cpu_rstd;
    logic [ADDR_W-1:0] r_im_addr;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic              w_xfer;
    logic              w_idle;
    logic              w_start_ok;
    logic              w_byte_valid;
    logic              w_last_byte;
    logic              w_last_word;
    logic              w_len_bad;
    logic [15:0]       w_len;
    logic [ADDR_W:0]   w_widx_next;

    assign w_xfer       = rx_valid && r_rx_ready;
    assign w_idle       = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
    assign w_start_ok   = start && w_idle;
    assign w_byte_valid = w_xfer && (r_state == ST_DATA);
    assign w_len        = {rx_data, r_len_lo};
    assign w_widx_next  = r_widx + 1'b1;
    assign w_last_word  = (32'(w_widx_next) == 32'(r_len));
    // The word index is one bit wider than the address so a full-depth image fits.
    assign w_len_bad    = 32'(w_len) > (32'd1 << ADDR_W);

    word_packer u_packer (
        .clk          (clk),
        .rstd         (rstd),
        .i_clr        (w_start_ok),
        .i_byte_valid (w_byte_valid),
        .i_byte       (rx_data),
        .o_last_byte  (w_last_byte),
        .o_word_valid (im_we),
        .o_word       (im_wdata)
    );

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            r_state    <= ST_IDLE;
            r_len_lo   <= 8'd0;
            r_len      <= 16'd0;
            r_widx     <= '0;
            r_rx_ready <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cpu_rstd <= 1'b0;
            r_im_addr  <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= CSUM_INIT;
`endif
        end else if (w_start_ok) begin
            r_state    <= ST_LEN_LO;
            r_rx_ready <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cpu_rstd <= 1'b0;
            r_widx     <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= CSUM_INIT;
`endif
        end else begin
            case (r_state)
                ST_LEN_LO: begin
                    if (w_xfer) begin
                        r_len_lo <= rx_data;
                        r_state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_xfer) begin
                        r_len <= w_len;
                        if (w_len == 16'd0) begin
                            r_state    <= ST_TAIL;
                            r_rx_ready <= TAIL_READY;
                        end else if (w_len_bad) begin
                            r_state    <= ST_ERROR;
                            r_rx_ready <= 1'b0;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
`ifdef LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ rx_data;
`endif
                        if (w_last_byte) begin
                            r_im_addr <= r_widx[ADDR_W-1:0];
                            r_widx    <= w_widx_next;
                            if (w_last_word) begin
                                r_state    <= ST_TAIL;
                                r_rx_ready <= TAIL_READY;
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_xfer) begin
                        r_rx_ready <= 1'b0;
                        r_state    <= (rx_data == r_csum) ? ST_DONE : ST_ERROR;
                    end
                end
`endif
                // Flags follow the state by one cycle, after the final write strobe.
                ST_DONE: begin
                    r_done     <= 1'b1;
                    r_cpu_rstd <= 1'b1;
                end
                ST_ERROR: begin
                    r_error    <= 1'b1;
                    r_cpu_rstd <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_ready = r_rx_ready;
    assign im_addr  = r_im_addr;
    assign cpu_rstd = r_cpu_rstd;
    assign done     = r_done;
    assign error    = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued by the stimulus
// and popped by a monitor on every im_we strobe.
module tb_program_loader;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              rstd;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_rstd;
    logic              done;
    logic              error;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [7:0]         stim[$];
    logic               prev_we = 1'b0;

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rstd     (rstd),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_rstd (cpu_rstd),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (im_we) begin
            if (prev_we) chk("we_single_cycle", 40'(prev_we), 40'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 40'({im_addr, im_wdata}), 40'd0);
            end else begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 40'(im_addr), 40'(e[ADDR_W+31:32]));
                chk("write_data", 40'(im_wdata), 40'(e[31:0]));
            end
        end
        prev_we = im_we;
    end

    task automatic exp_w(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic add_word(input logic [31:0] d);
        stim.push_back(d[31:24]);
        stim.push_back(d[23:16]);
        stim.push_back(d[15:8]);
        stim.push_back(d[7:0]);
    endtask

    task automatic add_trailer();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i < stim.size(); i++) x = x ^ stim[i];
        stim.push_back(x);
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("rx_ready_timeout", 40'(n), 40'd0);
        end else begin
            @(posedge clk);
        end
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_stim(input bit gaps);
        for (int i = 0; i < stim.size(); i++)
            send_byte(stim[i], gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    // Full load with end-of-load timing and final flag checks.
    task automatic run_load(input bit gaps, input bit exp_done, input bit exp_err);
        pulse_start();
        send_stim(gaps);
        @(negedge clk);
        chk("done_late", 40'(done), 40'd0);
        chk("error_late", 40'(error), 40'd0);
        chk("ready_drop", 40'(rx_ready), 40'd0);
        @(negedge clk);
        chk("done", 40'(done), 40'(exp_done));
        chk("error", 40'(error), 40'(exp_err));
        chk("cpu_rstd", 40'(cpu_rstd), 40'(exp_done));
        chk("rx_ready_end", 40'(rx_ready), 40'd0);
        repeat (3) @(negedge clk);
        chk("sb_empty", 40'(exp_q.size()), 40'd0);
        stim.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rstd     = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 40'(rx_ready), 40'd0);
        chk("rst_im_we", 40'(im_we), 40'd0);
        chk("rst_im_addr", 40'(im_addr), 40'd0);
        chk("rst_im_wdata", 40'(im_wdata), 40'd0);
        chk("rst_cpu_rstd", 40'(cpu_rstd), 40'd0);
        chk("rst_done", 40'(done), 40'd0);
        chk("rst_error", 40'(error), 40'd0);
        rstd = 1'b1;
        @(negedge clk);

        // N=2, gapless
        stim = '{8'h02, 8'h00};
        add_word(32'h12345678);
        add_word(32'h9ABCDEF0);
        add_trailer();
        exp_w(8'd0, 32'h12345678);
        exp_w(8'd1, 32'h9ABCDEF0);
        run_load(1'b0, 1'b1, 1'b0);

        // N=0
        stim = '{8'h00, 8'h00};
        add_trailer();
        run_load(1'b0, 1'b1, 1'b0);

        // N=257 exceeds depth
        stim = '{8'h01, 8'h01};
        run_load(1'b0, 1'b0, 1'b1);

        // N=3 with random valid gaps
        stim = '{8'h03, 8'h00};
        add_word(32'h01020304);
        add_word(32'hA0B0C0D0);
        add_word(32'hFFFF0000);
        add_trailer();
        exp_w(8'd0, 32'h01020304);
        exp_w(8'd1, 32'hA0B0C0D0);
        exp_w(8'd2, 32'hFFFF0000);
        run_load(1'b1, 1'b1, 1'b0);

        // Reset after 6 data bytes, then reload N=1
        stim = '{8'h02, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        exp_w(8'd0, 32'h12345678);
        pulse_start();
        send_stim(1'b0);
        stim.delete();
        @(negedge clk);
        rstd = 1'b0;
        #1;
        chk("mid_rst_rx_ready", 40'(rx_ready), 40'd0);
        chk("mid_rst_im_we", 40'(im_we), 40'd0);
        chk("mid_rst_cpu_rstd", 40'(cpu_rstd), 40'd0);
        chk("mid_rst_done", 40'(done), 40'd0);
        @(negedge clk);
        rstd = 1'b1;
        stim = '{8'h01, 8'h00};
        add_word(32'hDEADBEEF);
        add_trailer();
        exp_w(8'd0, 32'hDEADBEEF);
        run_load(1'b0, 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        exp_w(8'd0, 32'h11223344);
        run_load(1'b0, 1'b1, 1'b0);
        stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        exp_w(8'd0, 32'h11223344);
        run_load(1'b0, 1'b0, 1'b1);
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time writer for the instruction memory the processor core reads through its 8-bit `pc` index. Receives a byte stream over a valid/ready handshake, packs bytes into 32-bit big-endian instruction words, and writes them to consecutive instruction-memory addresses from 0. Holds the core in reset until the image is fully written, then releases it.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width; depth = 2**ADDR_W words.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rstd  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte; a transfer occurs on an edge where rx_valid && rx_ready.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  ADDR_W  word address for im_we.
- im_wdata  out  32  word to write.
- cpu_rstd  out  1  active-low reset driven to the core; low while not loaded.
- done  out  1  image fully written and accepted.
- error  out  1  load aborted.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N data bytes, each word MSB first (first byte -> [31:24]).
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM (macro only), DONE, ERROR.
- IDLE/DONE/ERROR: rx_ready=0; start -> LEN_LO, clears done, error, cpu_rstd, word index, byte index, checksum.
- start in LEN_LO/LEN_HI/DATA/CSUM: ignored.
- LEN_LO -> LEN_HI on transfer. LEN_HI on transfer: N=0 -> DONE (or CSUM); N > 2**ADDR_W -> ERROR; else DATA.
- DATA: 2-bit byte index shifts bytes into the word; on 4th byte, word registered to im_wdata, im_addr = word index, im_we pulsed; word index increments. After word N-1 -> DONE (or CSUM).
- Word index width ADDR_W+1 internally; im_addr is its low ADDR_W bits; N = 2**ADDR_W writes addresses 0..2**ADDR_W-1 with no wrap beyond.
- DONE: done=1, cpu_rstd=1. ERROR: error=1, cpu_rstd=0.
- rx_valid low stalls indefinitely; no timeout.

## Timing
- Reset values: rx_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_rstd=0, done=0, error=0, state IDLE.
- rx_ready registered; high from the cycle after start is sampled until the final byte (length, data, or checksum) is accepted.
- im_we high exactly one cycle, the cycle after the edge accepting the word's 4th byte; im_addr/im_wdata stable that cycle and held afterwards.
- Final data byte accepted at edge E: im_we high in cycle E+1; without checksum done and cpu_rstd rise after edge E+1.
- Throughput: one byte per cycle, back-to-back words need no stall.
- rstd asserted mid-load: immediate return to reset values; partially written memory not cleared; core held in reset.

## Configuration
- LOADER_CHECKSUM_EN defined: after data, CSUM state accepts one byte; must equal XOR of all 4·N data bytes (0x00 for N=0). Match -> DONE after that edge; mismatch -> ERROR. Words are already written either way.
- Undefined: no CSUM state, no trailer byte; DONE follows the last write directly.

## Structure
- Package loader_pkg: state encoding, LEN byte count (2), bytes-per-word (4), and checksum init (0x00).
- One sub-module: word_packer (byte shift register + byte index, emits word_valid pulse and 32-bit word); FSM, counters and checksum in program_loader.

## Test plan
- Reset then start, N=2, bytes 02 00 12 34 56 78 9A BC DE F0 at one per cycle -> im_we at addr 0 data 0x12345678, addr 1 data 0x9ABCDEF0; done=1, cpu_rstd=1.
- N=0 (bytes 00 00) -> no im_we, done=1 (with macro: after trailer 00).
- N=257 (01 01) with ADDR_W=8 -> error=1, cpu_rstd=0, no im_we, rx_ready=0.
- Random rx_valid gaps on N=3 -> identical writes to gapless run; im_we never more than one cycle per word.
- rstd low after 6 data bytes, then start and full N=1 load 0xDEADBEEF -> addr 0 = 0xDEADBEEF, done=1.
- LOADER_CHECKSUM_EN, N=1 data 11 22 33 44 trailer 44 -> done; trailer 45 -> error, cpu_rstd=0.
